// File: rtl/sync_rx_multi.sv
// Multi-channel receive-side bus synchroniser: per-channel toggle request sync, settle delay,
// capture with a one-cycle valid pulse, toggle ack back to the sender, sticky overrun flag.
module sync_rx_multi #(
  parameter int W           = 32,
  parameter int NCH         = 4,
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE_CYC  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH*W-1:0] in_data,
  input  logic [NCH-1:0]   in_req_tgl,
  output logic [NCH-1:0]   in_ack_tgl,
  output logic [NCH*W-1:0] out_data,
  output logic [NCH-1:0]   out_vld,
  input  logic             clr_err,
  output logic [NCH-1:0]   err_ovr
);

  typedef enum logic [1:0] {IDLE, WAIT, CAP, ACK} state_e;

  localparam bit         HAS_WAIT   = (SETTLE_CYC > 0);
  localparam logic [7:0] SETTLE_CNT = 8'(SETTLE_CYC);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_last_q, req_last_d;
    state_e                 state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   ack_q, ack_d;
    logic                   vld_q, vld_d;
    logic                   err_q, err_d;
    logic [W-1:0]           data_q, data_d;
    logic                   req_edge;

    assign req_edge = sync_q[SYNC_STAGES-1] ^ req_last_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        sync_q     <= '0;
        req_last_q <= 1'b0;
        state_q    <= IDLE;
        cnt_q      <= 8'd0;
        ack_q      <= 1'b0;
        vld_q      <= 1'b0;
        err_q      <= 1'b0;
        data_q     <= '0;
      end else begin
        sync_q     <= {sync_q[SYNC_STAGES-2:0], in_req_tgl[c]};
        req_last_q <= req_last_d;
        state_q    <= state_d;
        cnt_q      <= cnt_d;
        ack_q      <= ack_d;
        vld_q      <= vld_d;
        err_q      <= err_d;
        data_q     <= data_d;
      end
    end

    always_comb begin
      state_d    = state_q;
      req_last_d = req_last_q;
      cnt_d      = cnt_q;
      ack_d      = ack_q;
      vld_d      = 1'b0;
      data_d     = data_q;
      err_d      = err_q;

      case (state_q)
        IDLE: begin
          if (req_edge) begin
            req_last_d = sync_q[SYNC_STAGES-1];
            cnt_d      = SETTLE_CNT;
            if (HAS_WAIT) state_d = WAIT;
            else          state_d = CAP;
          end
        end
        WAIT: begin
          // Only reachable when a settle delay is configured.
          if (HAS_WAIT) begin
            cnt_d = cnt_q - 8'd1;
            if (cnt_q == 8'd1) state_d = CAP;
          end else begin
            state_d = IDLE;
          end
        end
        CAP: begin
          data_d  = in_data[c*W +: W];
          vld_d   = 1'b1;
          state_d = ACK;
        end
        ACK: begin
          ack_d   = ~ack_q;
          state_d = IDLE;
        end
      endcase

      // A request edge while busy stays pending; setting wins over a same-cycle clear.
      if (clr_err) err_d = 1'b0;
      if (req_edge && (state_q != IDLE)) err_d = 1'b1;
    end

    assign out_data[c*W +: W] = data_q;
    assign out_vld[c]         = vld_q;
    assign in_ack_tgl[c]      = ack_q;
    assign err_ovr[c]         = err_q;
  end

endmodule

// File: tb/tb_sync_rx_multi.sv
// Bench for sync_rx_multi: three builds (1ch/settle0, 1ch/settle3, 4ch/settle0) checked each cycle
// against a transaction-timeline model, plus directed literal expectations.
module tb_sync_rx_multi;

  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr_err;
  logic [31:0] din [3][4];
  logic [3:0]  req [3];

  logic [31:0]  o1_data, o2_data;
  logic [0:0]   o1_vld, o1_ack, o1_err, o2_vld, o2_ack, o2_err;
  logic [127:0] o4_data;
  logic [3:0]   o4_vld, o4_ack, o4_err;

  always #5 clk = ~clk;

  sync_rx_multi #(.W(32), .NCH(1), .SYNC_STAGES(SYNC), .SETTLE_CYC(0)) u1 (
    .clk(clk), .rst(rst), .in_data(din[0][0]), .in_req_tgl(req[0][0:0]),
    .in_ack_tgl(o1_ack), .out_data(o1_data), .out_vld(o1_vld),
    .clr_err(clr_err), .err_ovr(o1_err));

  sync_rx_multi #(.W(32), .NCH(1), .SYNC_STAGES(SYNC), .SETTLE_CYC(3)) u2 (
    .clk(clk), .rst(rst), .in_data(din[1][0]), .in_req_tgl(req[1][0:0]),
    .in_ack_tgl(o2_ack), .out_data(o2_data), .out_vld(o2_vld),
    .clr_err(clr_err), .err_ovr(o2_err));

  sync_rx_multi #(.W(32), .NCH(4), .SYNC_STAGES(SYNC), .SETTLE_CYC(0)) u4 (
    .clk(clk), .rst(rst), .in_data({din[2][3], din[2][2], din[2][1], din[2][0]}),
    .in_req_tgl(req[2]), .in_ack_tgl(o4_ack), .out_data(o4_data), .out_vld(o4_vld),
    .clr_err(clr_err), .err_ovr(o4_err));

  function automatic int nch_of(input int d);
    return (d == 2) ? 4 : 1;
  endfunction

  function automatic int settle_of(input int d);
    return (d == 1) ? 3 : 0;
  endfunction

  function automatic logic [31:0] g_data(input int d, input int c);
    case (d)
      0:       return o1_data;
      1:       return o2_data;
      default: return o4_data[c*32 +: 32];
    endcase
  endfunction

  function automatic logic [3:0] g_vld(input int d);
    case (d)
      0:       return {3'b000, o1_vld};
      1:       return {3'b000, o2_vld};
      default: return o4_vld;
    endcase
  endfunction

  function automatic logic [3:0] g_ack(input int d);
    case (d)
      0:       return {3'b000, o1_ack};
      1:       return {3'b000, o2_ack};
      default: return o4_ack;
    endcase
  endfunction

  function automatic logic [3:0] g_err(input int d);
    case (d)
      0:       return {3'b000, o1_err};
      1:       return {3'b000, o2_err};
      default: return o4_err;
    endcase
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int d, input int c,
                       input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d ch%0d: got %h expected %h", name, d, c, got, exp);
    end
  endtask

  // Model: each detected toggle is turned into absolute edge numbers for capture, ack
  // and the window of edges during which the overrun flag is being set.
  int         cyc = 0;
  bit         model_on = 1'b0;
  logic [3:0] prev_req [3];
  int         last_ack [12];
  int         cap_q [12][$];
  int         ack_q [12][$];
  int         elo_q [12][$];
  int         ehi_q [12][$];
  logic [31:0] m_data [3][4];
  logic [3:0]  m_vld [3];
  logic [3:0]  m_ack [3];
  logic [3:0]  m_err [3];

  always @(posedge clk) begin : model
    int se, st, cp, k;
    bit setting;
    cyc++;
    for (int d = 0; d < 3; d++) begin
      for (int c = 0; c < 4; c++) begin
        if (c < nch_of(d)) begin
          k = d * 4 + c;
          if (rst) begin
            cap_q[k].delete(); ack_q[k].delete(); elo_q[k].delete(); ehi_q[k].delete();
            last_ack[k] = -100;
            m_data[d][c] = '0;
            m_vld[d][c]  = 1'b0;
            m_ack[d][c]  = 1'b0;
            m_err[d][c]  = 1'b0;
          end else begin
            m_vld[d][c] = 1'b0;
            if (cap_q[k].size() > 0 && cap_q[k][0] == cyc) begin
              void'(cap_q[k].pop_front());
              m_vld[d][c]  = 1'b1;
              m_data[d][c] = din[d][c];
            end
            if (ack_q[k].size() > 0 && ack_q[k][0] == cyc) begin
              void'(ack_q[k].pop_front());
              m_ack[d][c] = ~m_ack[d][c];
            end
            while (ehi_q[k].size() > 0 && ehi_q[k][0] < cyc) begin
              void'(elo_q[k].pop_front());
              void'(ehi_q[k].pop_front());
            end
            setting = (elo_q[k].size() > 0 && elo_q[k][0] <= cyc);
            if (setting)      m_err[d][c] = 1'b1;
            else if (clr_err) m_err[d][c] = 1'b0;
            if (req[d][c] != prev_req[d][c]) begin
              // Toggle was applied after edge cyc-1; synchronised level changes after se.
              se = cyc - 1 + SYNC;
              if (se >= last_ack[k]) begin
                st = se + 1;
              end else begin
                elo_q[k].push_back(se + 1);
                ehi_q[k].push_back(last_ack[k]);
                st = last_ack[k] + 1;
              end
              cp = st + 1 + settle_of(d);
              cap_q[k].push_back(cp);
              ack_q[k].push_back(cp + 1);
              last_ack[k] = cp + 1;
            end
          end
          prev_req[d][c] = req[d][c];
        end
      end
    end
    if (rst) model_on = 1'b1;
  end

  always @(negedge clk) begin
    logic [3:0] vv, aa, ee;
    if (model_on) begin
      for (int d = 0; d < 3; d++) begin
        vv = g_vld(d);
        aa = g_ack(d);
        ee = g_err(d);
        for (int c = 0; c < 4; c++) begin
          if (c < nch_of(d)) begin
            check("cmp_vld", d, c, 32'(vv[c]), 32'(m_vld[d][c]));
            check("cmp_ack", d, c, 32'(aa[c]), 32'(m_ack[d][c]));
            check("cmp_err", d, c, 32'(ee[c]), 32'(m_err[d][c]));
            check("cmp_data", d, c, g_data(d, c), m_data[d][c]);
          end
        end
      end
    end
  end

  bit          t6_on = 1'b0;
  logic [31:0] got_q [$];
  logic [31:0] sent [$];

  always @(negedge clk) begin
    if (t6_on && o4_vld[1]) got_q.push_back(o4_data[63:32]);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [3:0]  av;
    logic        a0, exp_a;
    logic [31:0] w;
    int          n;

    rst = 1'b1;
    clr_err = 1'b0;
    for (int d = 0; d < 3; d++) begin
      req[d] = 4'b0000;
      for (int c = 0; c < 4; c++) din[d][c] = 32'h0;
    end
    tick(3);
    check("rst_vld", 2, 0, 32'(g_vld(2)), 32'h0);
    check("rst_ack", 2, 0, 32'(g_ack(2)), 32'h0);
    check("rst_err", 2, 0, 32'(g_err(2)), 32'h0);
    for (int c = 0; c < 4; c++) check("rst_data", 2, c, g_data(2, c), 32'h0);
    rst = 1'b0;
    tick(2);

    // T1: settle 0, capture visible after edge 4, ack after edge 5.
    din[0][0] = 32'hDEADBEEF;
    req[0][0] = ~req[0][0];
    tick(3);
    check("t1_vld_e3", 0, 0, 32'(g_vld(0)), 32'h0);
    tick(1);
    check("t1_vld_e4", 0, 0, 32'(g_vld(0)), 32'h1);
    check("t1_data_e4", 0, 0, g_data(0, 0), 32'hDEADBEEF);
    check("t1_ack_e4", 0, 0, 32'(g_ack(0)), 32'h0);
    tick(1);
    check("t1_vld_e5", 0, 0, 32'(g_vld(0)), 32'h0);
    check("t1_ack_e5", 0, 0, 32'(g_ack(0)), 32'h1);
    tick(3);

    // T2: settle 3, data changes during the settle wait.
    din[1][0] = 32'h1;
    req[1][0] = ~req[1][0];
    tick(4);
    din[1][0] = 32'h2;
    tick(2);
    check("t2_vld_e6", 1, 0, 32'(g_vld(1)), 32'h0);
    tick(1);
    check("t2_vld_e7", 1, 0, 32'(g_vld(1)), 32'h1);
    check("t2_data_e7", 1, 0, g_data(1, 0), 32'h2);
    tick(1);
    check("t2_ack_e8", 1, 0, 32'(g_ack(1)), 32'h1);
    tick(3);

    // T3: preload ch1, then ch0 and ch3 together.
    din[2][1] = 32'h5555;
    req[2][1] = ~req[2][1];
    tick(8);
    din[2][0] = 32'hA;
    din[2][3] = 32'hB;
    req[2] = req[2] ^ 4'b1001;
    tick(4);
    check("t3_vld", 2, 0, 32'(g_vld(2)), 32'h9);
    check("t3_data0", 2, 0, g_data(2, 0), 32'hA);
    check("t3_data3", 2, 3, g_data(2, 3), 32'hB);
    check("t3_data1", 2, 1, g_data(2, 1), 32'h5555);
    check("t3_data2", 2, 2, g_data(2, 2), 32'h0);
    tick(1);
    check("t3_ack", 2, 0, 32'(g_ack(2)), 32'hB);
    tick(3);

    // T4: overrun on ch2, set-beats-clear, then a plain clear.
    din[2][2] = 32'hC1;
    req[2][2] = ~req[2][2];
    tick(1);
    req[2][2] = ~req[2][2];
    tick(2);
    check("t4_err_e3", 2, 2, 32'(g_err(2)), 32'h0);
    tick(1);
    check("t4_err_e4", 2, 2, 32'(g_err(2)), 32'h4);
    check("t4_vld_e4", 2, 2, 32'(g_vld(2)), 32'h4);
    check("t4_data_e4", 2, 2, g_data(2, 2), 32'hC1);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    check("t4_err_setwins", 2, 2, 32'(g_err(2)), 32'h4);
    check("t4_ack_e5", 2, 2, 32'(g_ack(2)), 32'hF);
    din[2][2] = 32'hC2;
    tick(2);
    check("t4_vld_e7", 2, 2, 32'(g_vld(2)), 32'h4);
    check("t4_data_e7", 2, 2, g_data(2, 2), 32'hC2);
    tick(1);
    check("t4_ack_e8", 2, 2, 32'(g_ack(2)), 32'hB);
    tick(2);
    check("t4_err_sticky", 2, 2, 32'(g_err(2)), 32'h4);
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    check("t4_err_cleared", 2, 2, 32'(g_err(2)), 32'h0);
    tick(3);

    // T5: reset while u2 is waiting and u1 holds an overrun.
    din[1][0] = 32'h77;
    req[1][0] = ~req[1][0];
    din[0][0] = 32'h99;
    req[0][0] = ~req[0][0];
    tick(1);
    req[0][0] = ~req[0][0];
    tick(3);
    check("t5_err_pre", 0, 0, 32'(g_err(0)), 32'h1);
    rst = 1'b1;
    for (int d = 0; d < 3; d++) req[d] = 4'b0000;
    tick(2);
    rst = 1'b0;
    check("t5_vld", 1, 0, 32'(g_vld(1)), 32'h0);
    check("t5_ack", 1, 0, 32'(g_ack(1)), 32'h0);
    check("t5_data", 1, 0, g_data(1, 0), 32'h0);
    check("t5_err", 0, 0, 32'(g_err(0)), 32'h0);
    tick(4);
    check("t5_no_late_vld", 1, 0, 32'(g_vld(1)), 32'h0);
    check("t5_no_late_ack", 1, 0, 32'(g_ack(1)), 32'h0);
    din[1][0] = 32'h88;
    req[1][0] = ~req[1][0];
    tick(7);
    check("t5_fresh_vld", 1, 0, 32'(g_vld(1)), 32'h1);
    check("t5_fresh_data", 1, 0, g_data(1, 0), 32'h88);
    tick(1);
    check("t5_fresh_ack", 1, 0, 32'(g_ack(1)), 32'h1);
    tick(3);

    // T6: 100 legal back-to-back words on u4 ch1, sender waits for each ack.
    t6_on = 1'b1;
    for (int i = 0; i < 100; i++) begin
      w = $urandom;
      sent.push_back(w);
      din[2][1] = w;
      av = g_ack(2);
      a0 = av[1];
      req[2][1] = ~req[2][1];
      n = 0;
      do begin
        tick(1);
        n++;
        av = g_ack(2);
      end while (av[1] == a0 && n < 20);
      exp_a = ~a0;
      check("t6_ack", 2, 1, 32'(av[1]), 32'(exp_a));
    end
    tick(4);
    t6_on = 1'b0;
    check("t6_count", 2, 1, 32'(got_q.size()), 32'd100);
    for (int i = 0; i < 100 && i < got_q.size(); i++) check("t6_word", 2, 1, got_q[i], sent[i]);
    check("t6_err", 2, 1, 32'(g_err(2)), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
